gshare_predictor: RTL and testbench



---
 rtl/gshare_predictor.sv | 141 ++++++++++++++
 tb/tb_gshare_predictor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare_predictor: table of saturating counters indexed by PC bits, optionally
// XORed with a global taken/not-taken history (gshare), plus update and
// misprediction statistics for the performance counters.
module gshare_predictor #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 4,
  parameter int HIST_BITS  = 4,
  parameter int CTR_BITS   = 2,
  parameter int MODE       = 1,
  parameter int CTR_INIT   = (1 << CTR_BITS) - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  request,
  input  logic [PC_WIDTH-1:0]   req_pc,
  output logic                  prediction,
  output logic                  pred_valid,
  output logic [INDEX_BITS-1:0] pred_idx,
  input  logic                  result,
  input  logic                  taken,
  input  logic [INDEX_BITS-1:0] upd_idx,
  output logic [HIST_BITS-1:0]  ghr,
  output logic [15:0]           upd_count,
  output logic [15:0]           miss_count
);

  localparam int                DEPTH    = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_RST  = CTR_BITS'(CTR_INIT);
  localparam logic [15:0]        STAT_MAX = 16'hFFFF;

  logic [CTR_BITS-1:0]   table_q [DEPTH];
  logic [CTR_BITS-1:0]   table_d [DEPTH];
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic                  prediction_q, prediction_d;
  logic                  pred_valid_q, pred_valid_d;
  logic [INDEX_BITS-1:0] pred_idx_q, pred_idx_d;
  logic [15:0]           upd_count_q, upd_count_d;
  logic [15:0]           miss_count_q, miss_count_d;

  logic [INDEX_BITS-1:0] base_idx;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [CTR_BITS-1:0]   upd_ctr;
  logic                  unused_pc_bits;

  // Only the word-aligned index bits of the PC take part in the lookup.
  assign unused_pc_bits = ^{req_pc[PC_WIDTH-1:INDEX_BITS+2], req_pc[1:0]};

  // Form the lookup index from the PC, hashed with history in gshare mode.
  always_comb begin
    base_idx = req_pc[INDEX_BITS+1:2];
    if (MODE == 1) begin
      lookup_idx = base_idx ^ INDEX_BITS'(ghr_q);
    end else begin
      lookup_idx = base_idx;
    end
  end

  // Lookup reads the pre-update table so same-cycle updates are not seen.
  always_comb begin
    prediction_d = prediction_q;
    pred_idx_d   = pred_idx_q;
    pred_valid_d = request;
    if (request) begin
      prediction_d = table_q[lookup_idx][CTR_BITS-1];
      pred_idx_d   = lookup_idx;
    end
  end

  // Resolved branches nudge their counter toward the actual direction.
  always_comb begin
    table_d = table_q;
    upd_ctr = table_q[upd_idx];
    if (result) begin
      if (taken) begin
        if (upd_ctr != CTR_MAX) begin
          table_d[upd_idx] = upd_ctr + CTR_BITS'(1);
        end
      end else begin
        if (upd_ctr != '0) begin
          table_d[upd_idx] = upd_ctr - CTR_BITS'(1);
        end
      end
    end
  end

  // Shift resolved outcomes into the global history; bimodal keeps it at zero.
  always_comb begin
    ghr_d = ghr_q;
    if (MODE != 1) begin
      ghr_d = '0;
    end else if (result) begin
      ghr_d = HIST_BITS'({ghr_q, taken});
    end
  end

  // Saturating statistics; a miss is judged against the pre-update counter.
  always_comb begin
    upd_count_d  = upd_count_q;
    miss_count_d = miss_count_q;
    if (result) begin
      if (upd_count_q != STAT_MAX) begin
        upd_count_d = upd_count_q + 16'd1;
      end
      if ((upd_ctr[CTR_BITS-1] != taken) && (miss_count_q != STAT_MAX)) begin
        miss_count_d = miss_count_q + 16'd1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= CTR_RST;
      end
      ghr_q        <= '0;
      prediction_q <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_idx_q   <= '0;
      upd_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      table_q      <= table_d;
      ghr_q        <= ghr_d;
      prediction_q <= prediction_d;
      pred_valid_q <= pred_valid_d;
      pred_idx_q   <= pred_idx_d;
      upd_count_q  <= upd_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign prediction = prediction_q;
  assign pred_valid = pred_valid_q;
  assign pred_idx   = pred_idx_q;
  assign ghr        = ghr_q;
  assign upd_count  = upd_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: one gshare and one bimodal instance driven side
// by side and compared every cycle against an arithmetic reference model.
module tb_gshare_predictor;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  // Instance 1 = gshare, instance 0 = bimodal.
  logic        g_request = 1'b0, g_result = 1'b0, g_taken = 1'b0;
  logic [31:0] g_req_pc = '0;
  logic [3:0]  g_upd_idx = '0;
  logic        g_prediction, g_pred_valid;
  logic [3:0]  g_pred_idx, g_ghr;
  logic [15:0] g_upd_count, g_miss_count;

  logic        b_request = 1'b0, b_result = 1'b0, b_taken = 1'b0;
  logic [31:0] b_req_pc = '0;
  logic [3:0]  b_upd_idx = '0;
  logic        b_prediction, b_pred_valid;
  logic [3:0]  b_pred_idx, b_ghr;
  logic [15:0] b_upd_count, b_miss_count;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state, indexed by instance (0 bimodal, 1 gshare).
  int ctr_m [2][16];
  int ghr_m [2];
  int upd_m [2];
  int miss_m [2];
  int pidx_m [2];
  int pred_m [2];
  int pvalid_m [2];

  gshare_predictor #(.MODE(1)) dut_gs (
    .clk(clk), .rst_n(rst_n), .request(g_request), .req_pc(g_req_pc),
    .prediction(g_prediction), .pred_valid(g_pred_valid), .pred_idx(g_pred_idx),
    .result(g_result), .taken(g_taken), .upd_idx(g_upd_idx), .ghr(g_ghr),
    .upd_count(g_upd_count), .miss_count(g_miss_count)
  );

  gshare_predictor #(.MODE(0)) dut_bm (
    .clk(clk), .rst_n(rst_n), .request(b_request), .req_pc(b_req_pc),
    .prediction(b_prediction), .pred_valid(b_pred_valid), .pred_idx(b_pred_idx),
    .result(b_result), .taken(b_taken), .upd_idx(b_upd_idx), .ghr(b_ghr),
    .upd_count(b_upd_count), .miss_count(b_miss_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 16; k++) ctr_m[u][k] = 3;
      ghr_m[u] = 0; upd_m[u] = 0; miss_m[u] = 0;
      pidx_m[u] = 0; pred_m[u] = 0; pvalid_m[u] = 0;
    end
  endtask

  // One clock edge of behaviour: lookup sees the state before this edge's update.
  task automatic modelStep(input int u, input bit req, input logic [31:0] pc,
                           input bit res, input bit tk, input int uidx);
    int look;
    look = (pc / 4) % 16;
    if (u == 1) look = look ^ ghr_m[u];
    if (req) begin
      pred_m[u] = (ctr_m[u][look] >= 2) ? 1 : 0;
      pidx_m[u] = look;
    end
    pvalid_m[u] = req ? 1 : 0;
    if (res) begin
      if (((ctr_m[u][uidx] >= 2) ? 1 : 0) != int'(tk)) begin
        miss_m[u] = (miss_m[u] < 65535) ? miss_m[u] + 1 : 65535;
      end
      upd_m[u] = (upd_m[u] < 65535) ? upd_m[u] + 1 : 65535;
      if (tk) ctr_m[u][uidx] = (ctr_m[u][uidx] < 3) ? ctr_m[u][uidx] + 1 : 3;
      else    ctr_m[u][uidx] = (ctr_m[u][uidx] > 0) ? ctr_m[u][uidx] - 1 : 0;
      if (u == 1) ghr_m[u] = (ghr_m[u] * 2 + int'(tk)) % 16;
    end
  endtask

  task automatic checkModel();
    checkOutput("gs_pred",  32'(g_prediction), 32'(pred_m[1]));
    checkOutput("gs_valid", 32'(g_pred_valid), 32'(pvalid_m[1]));
    checkOutput("gs_idx",   32'(g_pred_idx),   32'(pidx_m[1]));
    checkOutput("gs_ghr",   32'(g_ghr),        32'(ghr_m[1]));
    checkOutput("gs_upd",   32'(g_upd_count),  32'(upd_m[1]));
    checkOutput("gs_miss",  32'(g_miss_count), 32'(miss_m[1]));
    checkOutput("bm_pred",  32'(b_prediction), 32'(pred_m[0]));
    checkOutput("bm_valid", 32'(b_pred_valid), 32'(pvalid_m[0]));
    checkOutput("bm_idx",   32'(b_pred_idx),   32'(pidx_m[0]));
    checkOutput("bm_ghr",   32'(b_ghr),        32'(ghr_m[0]));
    checkOutput("bm_upd",   32'(b_upd_count),  32'(upd_m[0]));
    checkOutput("bm_miss",  32'(b_miss_count), 32'(miss_m[0]));
  endtask

  // Drive both instances for one cycle, advance the model, then compare.
  task automatic applyStimulus(input bit gq, input logic [31:0] gpc, input bit gr, input bit gt, input logic [3:0] gi,
                               input bit bq, input logic [31:0] bpc, input bit br, input bit bt, input logic [3:0] bi);
    g_request = gq; g_req_pc = gpc; g_result = gr; g_taken = gt; g_upd_idx = gi;
    b_request = bq; b_req_pc = bpc; b_result = br; b_taken = bt; b_upd_idx = bi;
    @(posedge clk);
    modelStep(1, gq, gpc, gr, gt, int'(gi));
    modelStep(0, bq, bpc, br, bt, int'(bi));
    #1;
    checkModel();
  endtask

  task automatic gsStep(input bit q, input logic [31:0] pc, input bit r, input bit t, input logic [3:0] i);
    applyStimulus(q, pc, r, t, i, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic bmStep(input bit q, input logic [31:0] pc, input bit r, input bit t, input logic [3:0] i);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, q, pc, r, t, i);
  endtask

  initial begin
    modelReset();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_gs_valid", 32'(g_pred_valid), 32'h0);
    checkOutput("rst_gs_pred",  32'(g_prediction), 32'h0);
    checkOutput("rst_gs_ghr",   32'(g_ghr),        32'h0);
    checkOutput("rst_bm_upd",   32'(b_upd_count),  32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First lookups in gshare mode after reset.
    gsStep(1'b1, 32'h40, 1'b0, 1'b0, 4'h0);
    checkOutput("first_valid", 32'(g_pred_valid), 32'h1);
    checkOutput("first_pred",  32'(g_prediction), 32'h1);
    checkOutput("first_idx",   32'(g_pred_idx),   32'h0);
    gsStep(1'b1, 32'h44, 1'b0, 1'b0, 4'h0);
    checkOutput("second_idx",  32'(g_pred_idx),   32'h1);
    checkOutput("second_pred", 32'(g_prediction), 32'h1);

    // Bimodal counter saturating at zero.
    for (int k = 0; k < 4; k++) bmStep(1'b0, 32'h0, 1'b1, 1'b0, 4'h1);
    checkOutput("sat_upd",  32'(b_upd_count),  32'd4);
    checkOutput("sat_miss", 32'(b_miss_count), 32'd2);
    bmStep(1'b1, 32'h44, 1'b0, 1'b0, 4'h0);
    checkOutput("sat_pred0", 32'(b_prediction), 32'h0);
    bmStep(1'b0, 32'h0, 1'b1, 1'b1, 4'h1);
    bmStep(1'b1, 32'h44, 1'b0, 1'b0, 4'h0);
    checkOutput("sat_pred1", 32'(b_prediction), 32'h0);

    // Global history build-up and hashed lookup.
    gsStep(1'b0, 32'h0, 1'b1, 1'b1, 4'h0);
    gsStep(1'b0, 32'h0, 1'b1, 1'b0, 4'h0);
    gsStep(1'b0, 32'h0, 1'b1, 1'b1, 4'h0);
    gsStep(1'b0, 32'h0, 1'b1, 1'b1, 4'h0);
    checkOutput("hist_ghr", 32'(g_ghr), 32'hB);
    gsStep(1'b1, 32'h40, 1'b0, 1'b0, 4'h0);
    checkOutput("hist_idx",  32'(g_pred_idx),   32'hB);
    checkOutput("hist_pred", 32'(g_prediction), 32'h1);

    // Read-before-write on a simultaneous lookup and update of the same entry.
    bmStep(1'b0, 32'h0, 1'b1, 1'b0, 4'h5);
    bmStep(1'b1, 32'h54, 1'b1, 1'b0, 4'h5);
    checkOutput("rbw_pred_old", 32'(b_prediction), 32'h1);
    bmStep(1'b1, 32'h54, 1'b0, 1'b0, 4'h0);
    checkOutput("rbw_pred_new", 32'(b_prediction), 32'h0);

    // Asynchronous reset between edges, with a request still pending in gshare.
    gsStep(1'b1, 32'h40, 1'b0, 1'b0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_ghr",   32'(g_ghr),        32'h0);
    checkOutput("arst_upd",   32'(g_upd_count),  32'h0);
    checkOutput("arst_miss",  32'(g_miss_count), 32'h0);
    checkOutput("arst_pred",  32'(g_prediction), 32'h0);
    checkOutput("arst_valid", 32'(g_pred_valid), 32'h0);
    checkOutput("arst_idx",   32'(g_pred_idx),   32'h0);
    checkOutput("arst_bmupd", 32'(b_upd_count),  32'h0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h6C, 1'b0, 1'b0, 4'h0, 1'b1, 32'h54, 1'b0, 1'b0, 4'h0);
    checkOutput("arst_look_gs", 32'(g_prediction), 32'h1);
    checkOutput("arst_look_bm", 32'(b_prediction), 32'h1);

    // Randomised traffic on both instances, including overlapping request/result.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 4'($urandom),
                    1'($urandom), $urandom, 1'($urandom), 1'($urandom), 4'($urandom));
    end

    // Statistics saturation: every update mispredicts (taken opposes the MSB).
    g_request = 1'b0; g_result = 1'b0;
    b_request = 1'b0; b_result = 1'b1; b_upd_idx = 4'h7;
    for (int n = 0; n < 65540; n++) begin
      b_taken = (ctr_m[0][7] >= 2) ? 1'b0 : 1'b1;
      @(posedge clk);
      modelStep(1, 1'b0, 32'h0, 1'b0, 1'b0, 0);
      modelStep(0, 1'b0, 32'h0, 1'b1, b_taken, 7);
      #1;
    end
    checkOutput("stat_upd_sat",  32'(b_upd_count),  32'hFFFF);
    checkOutput("stat_miss_sat", 32'(b_miss_count), 32'hFFFF);
    bmStep(1'b0, 32'h0, 1'b1, (ctr_m[0][7] >= 2) ? 1'b0 : 1'b1, 4'h7);
    checkOutput("stat_upd_hold",  32'(b_upd_count),  32'hFFFF);
    checkOutput("stat_miss_hold", 32'(b_miss_count), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
